// File: rtl/uart_pkg.sv
// Shared UART definitions used by the receiver and the transmitter on the same system clock.
//
// Contents:
//   - DATA_BITS         : data bits per frame (8N1 framing)
//   - DEFAULT_CLK_FREQ  : system clock frequency in Hz
//   - IDLE..WAIT_IDLE   : state encodings; the transmitter uses the same codes
//   - uart_state_e      : typed FSM state built on those encodings
//   - bit_cycles()      : clocks per bit for a clock/baud pair
package uart_pkg;

  localparam int unsigned DATA_BITS        = 8;
  localparam int unsigned DEFAULT_CLK_FREQ = 100_000_000;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
  localparam logic [2:0] STOP      = 3'd3;
  localparam logic [2:0] WAIT_IDLE = 3'd4;

  typedef enum logic [2:0] {
    StIdle     = IDLE,
    StStart    = START,
    StData     = DATA,
    StStop     = STOP,
    StWaitIdle = WAIT_IDLE
  } uart_state_e;

  function automatic int unsigned bit_cycles(input int unsigned clk_freq,
                                             input int unsigned baudrate);
    return clk_freq / baudrate;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for a single asynchronous input.
//
// Ports:
//   clk_i  : destination clock
//   rst_ni : asynchronous active-low reset; both flops load ResetValue
//   d_i    : asynchronous input
//   q_o    : synchronized output, two clk_i cycles of latency
module uart_sync #(
  parameter bit ResetValue = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= ResetValue;
      sync_q <= ResetValue;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver. Idle-high line, one start bit, eight data bits LSB first, one stop bit.
// The line is synchronized, a falling edge starts a frame, the start bit is re-checked at its
// middle, and each data bit and the stop bit are sampled once at their middles.
//
// Ports:
//   clk       : system clock, rising edge
//   rst_n     : asynchronous active-low reset
//   rx        : serial line, asynchronous to clk
//   dout      : last correctly framed byte, held until the next good frame
//   done      : one-cycle pulse, dout valid from this cycle
//   frame_err : one-cycle pulse, stop bit sampled low (dout not updated)
//   busy      : high from start detect until the FSM is back in idle
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = DEFAULT_CLK_FREQ,
  parameter int unsigned BAUDRATE = 10_000_000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] dout,
  output logic                 done,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int unsigned BIT_CYCLES  = bit_cycles(CLK_FREQ, BAUDRATE);
  localparam int unsigned HALF_CYCLES = BIT_CYCLES / 2;
  localparam int unsigned TimerW      = $clog2(BIT_CYCLES);

  if (BIT_CYCLES < 4) begin : gen_cfg_check
    $error("uart_rx: CLK_FREQ/BAUDRATE must be at least 4");
  end

  // ---------------------------------------------------------------------------
  // Line synchronizer and falling-edge detect
  // ---------------------------------------------------------------------------
  logic rx_s;
  logic rx_prev_q;
  logic rx_fall;

  uart_sync #(
    .ResetValue(1'b1)
  ) u_rx_sync (
    .clk_i (clk),
    .rst_ni(rst_n),
    .d_i   (rx),
    .q_o   (rx_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_prev_q <= 1'b1;
    end else begin
      rx_prev_q <= rx_s;
    end
  end

  assign rx_fall = rx_prev_q & ~rx_s;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  uart_state_e          state_q, state_d;
  logic [TimerW-1:0]    timer_q, timer_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] dout_q, dout_d;
  logic                 done_q, done_d;
  logic                 ferr_q, ferr_d;

  logic half_tick;
  logic bit_tick;
  logic last_bit;

  assign half_tick = (timer_q == TimerW'(HALF_CYCLES - 1));
  assign bit_tick  = (timer_q == TimerW'(BIT_CYCLES - 1));
  assign last_bit  = (bit_cnt_q == 3'(DATA_BITS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      timer_q   <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      dout_q    <= '0;
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      dout_q    <= dout_d;
      done_q    <= done_d;
      ferr_q    <= ferr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (rx_fall) begin
          state_d = StStart;
        end
      end
      StStart: begin
        // A line that is high again at mid start bit was only a glitch.
        if (half_tick) begin
          state_d = rx_s ? StIdle : StData;
        end
      end
      StData: begin
        if (bit_tick && last_bit) begin
          state_d = StStop;
        end
      end
      StStop: begin
        if (bit_tick) begin
          state_d = rx_s ? StIdle : StWaitIdle;
        end
      end
      StWaitIdle: begin
        // Hold off until the line returns high so a break yields a single error.
        if (rx_s) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Timer, datapath and strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    timer_d   = '0;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    dout_d    = dout_q;
    done_d    = 1'b0;
    ferr_d    = 1'b0;
    busy      = (state_q != StIdle);

    // The timer runs only while timing a bit and restarts on every state change;
    // in DATA it also wraps at the end of each bit.
    if ((state_d == state_q) &&
        ((state_q == StStart) || (state_q == StData) || (state_q == StStop))) begin
      timer_d = bit_tick ? '0 : timer_q + 1'b1;
    end

    case (state_q)
      StStart: begin
        if (half_tick && !rx_s) begin
          bit_cnt_d = '0;
        end
      end
      StData: begin
        if (bit_tick) begin
          // LSB arrives first, so shifting in at the top leaves bit 0 at the bottom.
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          if (!last_bit) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      StStop: begin
        if (bit_tick) begin
          if (rx_s) begin
            dout_d = shift_q;
            done_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign dout      = dout_q;
  assign done      = done_q;
  assign frame_err = ferr_q;

endmodule
